// File: rtl/mips16_alu_pkg.sv
// Shared definitions for the MIPS-16b ALU arithmetic path: state codes,
// operation codes and the default datapath width.
package mips16_alu_pkg;

  localparam int DATA_W = 16;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_RUN  = 2'd1;
  localparam state_t S_DONE = 2'd2;

  localparam logic ALU_OP_ADD = 1'b0;
  localparam logic ALU_OP_SUB = 1'b1;

endpackage

// File: rtl/serial_add_sub_full_add_sub.sv
// One-bit add/subtract cell: i_sub inverts B so that a subtract becomes
// A + ~B + cin, with the caller seeding cin = 1 on the LSB.
module Full_Add_Sub (
  input  logic i_a,
  input  logic i_b,
  input  logic i_sub,
  input  logic i_cin,
  output logic o_s,
  output logic o_c
);

  logic w_b_eff;
  logic w_p;

  assign w_b_eff = i_b ^ i_sub;
  assign w_p     = i_a ^ w_b_eff;
  assign o_s     = w_p ^ i_cin;
  assign o_c     = (i_a & w_b_eff) | (i_cin & w_p);

endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial WIDTH-bit add/subtract, LSB first through a single cell.
// Optional overflow/zero flags are built only when SERIAL_ADD_SUB_FLAGS_EN is defined.
module serial_add_sub
  import mips16_alu_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t             r_state;
  logic [WIDTH-1:0]   r_a_sh;
  logic [WIDTH-1:0]   r_b_sh;
  logic [WIDTH-1:0]   r_result;
  logic               r_carry;
  logic               r_sub;
  logic               r_cout;
  logic [CNT_W-1:0]   r_bit_cnt;

  logic               w_s;
  logic               w_c;
  logic               w_last;
  logic               w_accept;
  logic [WIDTH-1:0]   w_result_next;

  Full_Add_Sub u_cell (
    .i_a   (r_a_sh[0]),
    .i_b   (r_b_sh[0]),
    .i_sub (r_sub),
    .i_cin (r_carry),
    .o_s   (w_s),
    .o_c   (w_c)
  );

  assign w_last        = (r_bit_cnt == CNT_W'(WIDTH - 1));
  assign w_accept      = (r_state == S_IDLE) && start;
  assign w_result_next = {w_s, r_result[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_a_sh    <= '0;
      r_b_sh    <= '0;
      r_result  <= '0;
      r_carry   <= 1'b0;
      r_sub     <= 1'b0;
      r_cout    <= 1'b0;
      r_bit_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a_sh    <= a;
            r_b_sh    <= b;
            r_carry   <= op_sub;
            r_sub     <= op_sub;
            r_bit_cnt <= '0;
            r_result  <= '0;
            r_cout    <= 1'b0;
            r_state   <= S_RUN;
          end
        end
        S_RUN: begin
          r_result <= w_result_next;
          r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
          r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
          r_carry  <= w_c;
          if (w_last) begin
            r_cout  <= w_c;
            r_state <= S_DONE;
          end else begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef SERIAL_ADD_SUB_FLAGS_EN
  logic r_overflow;
  logic r_zero;

  // On the MSB step r_carry is the carry into the sign bit, w_c the carry out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
      r_zero     <= 1'b0;
    end else if (w_accept) begin
      r_overflow <= 1'b0;
      r_zero     <= 1'b0;
    end else if ((r_state == S_RUN) && w_last) begin
      r_overflow <= r_carry ^ w_c;
      r_zero     <= (w_result_next == '0);
    end
  end

  assign overflow = r_overflow;
  assign zero     = r_zero;
`else
  assign overflow = 1'b0;
  assign zero     = 1'b0;
`endif

  assign busy   = (r_state != S_IDLE);
  assign done   = (r_state == S_DONE);
  assign result = r_result;
  assign cout   = r_cout;

endmodule

// File: tb/tb_serial_add_sub.sv
// Scoreboard bench for serial_add_sub: directed corner cases plus random
// operations checked against an integer-arithmetic reference model.
module tb_serial_add_sub;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        op_sub = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        busy, done, cout, overflow, zero;
  logic [15:0] result;

  serial_add_sub #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_sub(op_sub),
    .a(a), .b(b), .busy(busy), .done(done), .result(result),
    .cout(cout), .overflow(overflow), .zero(zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] ea;
    logic [15:0] eb;
    logic        esub;
    logic [15:0] res;
    logic        co;
    logic        ov;
    logic        z;
    int          c0;
  } exp_t;

  exp_t sb[$];
  int compared = 0;
  int mismatched = 0;
  int pushed = 0;
  int dones = 0;

`ifdef SERIAL_ADD_SUB_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  // Reference: plain integer arithmetic on unsigned and signed views.
  function automatic exp_t model(logic [15:0] xa, logic [15:0] xb, logic xs);
    exp_t e;
    int ua = xa;
    int ub = xb;
    int sa = $signed(xa);
    int sbv = $signed(xb);
    int r, sr;
    if (xs) begin
      r = ua - ub; sr = sa - sbv; e.co = (ua >= ub);
    end else begin
      r = ua + ub; sr = sa + sbv; e.co = (r > 65535);
    end
    e.res = 16'(r & 32'hFFFF);
    e.ov  = FLAGS && (sr > 32767 || sr < -32768);
    e.z   = FLAGS && (e.res == 16'h0000);
    e.ea = xa; e.eb = xb; e.esub = xs; e.c0 = 0;
    return e;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic issue(logic [15:0] xa, logic [15:0] xb, logic xs, exp_t e);
    @(negedge clk);
    a = xa; b = xb; op_sub = xs; start = 1'b1;
    e.ea = xa; e.eb = xb; e.esub = xs; e.c0 = cyc;
    sb.push_back(e);
    pushed++;
    @(negedge clk);
    start = 1'b0;
    a = $urandom; b = $urandom; op_sub = $urandom_range(0, 1);
  endtask

  task automatic wait_empty();
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL done_timeout pending=%0d required=0", sb.size());
      sb.delete();
    end
  endtask

  exp_t last;
  bit   have_last = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      have_last = 1'b0;
    end else if (done) begin
      dones++;
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_done actual=1 required=0");
      end else begin
        exp_t e;
        e = sb.pop_front();
        $display("op %04h %s %04h -> result=%04h cout=%0d ovf=%0d zero=%0d", e.ea,
                 e.esub ? "-" : "+", e.eb, result, cout, overflow, zero);
        chk("result", 32'(result), 32'(e.res));
        chk("cout", 32'(cout), 32'(e.co));
        chk("overflow", 32'(overflow), 32'(e.ov));
        chk("zero", 32'(zero), 32'(e.z));
        chk("busy_at_done", 32'(busy), 32'd1);
        chk("latency", 32'(cyc - e.c0), 32'd17);
        last = e;
        have_last = 1'b1;
      end
    end else if (!busy && have_last) begin
      chk("hold_result", 32'(result), 32'(last.res));
      chk("hold_cout", 32'(cout), 32'(last.co));
    end
  end

  typedef struct {
    logic [15:0] da;
    logic [15:0] db;
    logic        ds;
    logic [15:0] dres;
    logic        dco;
    logic        dov;
    logic        dz;
  } dir_t;

  dir_t dir_tab[6] = '{
    '{16'h1234, 16'h0FF1, 1'b0, 16'h2225, 1'b0, 1'b0, 1'b0},
    '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0},
    '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0},
    '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1},
    '{16'h8000, 16'h8000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1},
    '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1}
  };

  task automatic check_all_zero(string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_result"}, 32'(result), 32'd0);
    chk({tag, "_cout"}, 32'(cout), 32'd0);
    chk({tag, "_overflow"}, 32'(overflow), 32'd0);
    chk({tag, "_zero"}, 32'(zero), 32'd0);
  endtask

  initial begin
    exp_t e;
    #1;
    check_all_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed corners with hand-derived expectations.
    foreach (dir_tab[i]) begin
      e.res = dir_tab[i].dres;
      e.co  = dir_tab[i].dco;
      e.ov  = FLAGS && dir_tab[i].dov;
      e.z   = FLAGS && dir_tab[i].dz;
      issue(dir_tab[i].da, dir_tab[i].db, dir_tab[i].ds, e);
      wait_empty();
    end

    // A second start mid-RUN must be dropped.
    issue(16'h1111, 16'h2222, 1'b0, model(16'h1111, 16'h2222, 1'b0));
    repeat (4) @(negedge clk);
    a = 16'hAAAA; b = 16'h5555; op_sub = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_empty();
    repeat (20) @(negedge clk);

    // Reset mid-RUN discards the operation.
    issue(16'h4321, 16'h1234, 1'b1, model(16'h4321, 16'h1234, 1'b1));
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    pushed--;
    #1;
    check_all_zero("midrun_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    e.res = 16'h0002; e.co = 1'b0; e.ov = 1'b0; e.z = 1'b0;
    issue(16'h0001, 16'h0001, 1'b0, e);
    wait_empty();

    // Random traffic against the model.
    for (int k = 0; k < 30; k++) begin
      logic [15:0] ra, rb;
      logic        rs;
      ra = $urandom;
      rb = $urandom;
      rs = $urandom_range(0, 1);
      if (k % 5 == 0) rb = ra;
      issue(ra, rb, rs, model(ra, rb, rs));
      wait_empty();
    end

    repeat (3) @(negedge clk);
    chk("done_count", 32'(dones), 32'(pushed));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
